bram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 2^SIZE x 32 block RAM (`blram`) between the VSCPU core and a second requester, such as a program loader or debug port. Each master issues one word access per cycle through a req/gnt handshake. The arbiter serialises accesses with round-robin priority and supports a lock for atomic read-modify-write sequences. It tracks the RAM's one-cycle read latency and routes each returned word to the master that requested it. It sits between the masters and `blram`, replacing the direct CPU-to-RAM connection.

---
 rtl/vscpu_pkg.sv | 17 +
 rtl/bram_arbiter_rr_pick2.sv | 13 +
 rtl/bram_arbiter.sv | 117 +++++++++++
 tb/tb_bram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscpu_pkg.sv
// Shared definitions for the VSCPU memory subsystem: arbiter state encodings,
// master ids and default RAM geometry.
package vscpu_pkg;

   localparam int SIZE_DEF = 14;
   localparam int DW_DEF   = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

endpackage

// File: rtl/bram_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that was not granted last wins.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt0,
   output logic gnt1
);

   assign gnt0 = req0 & (~req1 | last);
   assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM between the CPU (master 0) and an auxiliary
// master with round-robin priority, lock ownership and read-return routing.
module bram_arbiter
   import vscpu_pkg::*;
#(
   parameter int SIZE = SIZE_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic            m0_lock,
   input  logic [SIZE-1:0] m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic            m1_lock,
   input  logic [SIZE-1:0] m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic            mem_wrEn,
   output logic [SIZE-1:0] mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   output logic [1:0]      dbg_state_o
);

   // Handshake: a master raises req with addr/we/wdata/lock stable and keeps them
   // stable until it sees gnt in the same cycle; gnt high means the access
   // happens at this rising edge. Reads return rvalid/rdata exactly one cycle later.

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic       rd_pend_q, rd_pend_d;
   logic       rd_id_q, rd_id_d;

   logic pick0, pick1;
   logic granted, sel, g_we, g_lock;

   rr_pick2 u_pick (
      .req0 (m0_req),
      .req1 (m1_req),
      .last (last_q),
      .gnt0 (pick0),
      .gnt1 (pick1)
   );

   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            m0_gnt = pick0;
            m1_gnt = pick1;
         end
         ST_OWN0: m0_gnt = m0_req;
         ST_OWN1: m1_gnt = m1_req;
         default: ;
      endcase
      if (!rst) begin
         m0_gnt = 1'b0;
         m1_gnt = 1'b0;
      end

      // With no grant sel stays 0, so master 0's address reaches the RAM.
      granted   = m0_gnt | m1_gnt;
      sel       = m1_gnt;
      g_we      = sel ? m1_we   : m0_we;
      g_lock    = sel ? m1_lock : m0_lock;
      mem_addr  = sel ? m1_addr  : m0_addr;
      mem_wdata = sel ? m1_wdata : m0_wdata;
      mem_wrEn  = granted & g_we;

      state_d   = state_q;
      last_d    = last_q;
      rd_pend_d = 1'b0;
      rd_id_d   = rd_id_q;
      if (granted) begin
         last_d  = sel;
         state_d = g_lock ? (sel ? ST_OWN1 : ST_OWN0) : ST_IDLE;
         if (!g_we) begin
            rd_pend_d = 1'b1;
            rd_id_d   = sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         last_q    <= M_AUX;
         rd_pend_q <= 1'b0;
         rd_id_q   <= M_CPU;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
      end
   end

   always_comb begin
      m0_rvalid = rst & rd_pend_q & (rd_id_q == M_CPU);
      m1_rvalid = rst & rd_pend_q & (rd_id_q == M_AUX);
      m0_rdata  = m0_rvalid ? mem_rdata : '0;
      m1_rdata  = m1_rvalid ? mem_rdata : '0;
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level model of the arbiter and RAM.
module tb_bram_arbiter;

   logic        clk, rst;
   logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [13:0] m0_addr, m1_addr, mem_addr;
   logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wrEn;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   bram_arbiter #(.SIZE(14), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_wrEn(mem_wrEn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      case (i)
         100: return 32'd5;
         101: return 32'h0000_000A;
         102: return 32'h0000_003D;
         103: return 32'hFFFF_FFFF;
         default: return i * 32'h9E37_79B1;
      endcase
   endfunction

   // Behavioural block RAM: registered read, write lands at the edge.
   logic [31:0] ram [0:16383];
   initial begin
      for (int i = 0; i < 16384; i++) ram[i] = init_word(i);
      forever begin
         @(posedge clk);
         mem_rdata <= ram[mem_addr];
         if (mem_wrEn) ram[mem_addr] = mem_wdata;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_m0(input logic r, input logic we, input logic lk,
                         input logic [13:0] a, input logic [31:0] d);
      m0_req = r; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
   endtask

   task automatic set_m1(input logic r, input logic we, input logic lk,
                         input logic [13:0] a, input logic [31:0] d);
      m1_req = r; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [31:0] ref_mem [0:16383];
   int          mdl_owner;        // -1 nobody, else owning master
   logic        mdl_last;
   logic [31:0] exp_q[$];         // read data due next cycle
   logic        id_q[$];          // master that should receive it
   logic        e_g0, e_g1, e_wren, e_rv0, e_rv1;
   logic [13:0] e_addr;
   logic [31:0] e_wdata, e_rd0, e_rd1;
   logic [1:0]  e_state;

   task automatic model_eval();
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (rst) begin
         if (mdl_owner == 0)      e_g0 = m0_req;
         else if (mdl_owner == 1) e_g1 = m1_req;
         else if (m0_req && m1_req) begin
            if (mdl_last) e_g0 = 1'b1;
            else          e_g1 = 1'b1;
         end else begin
            e_g0 = m0_req;
            e_g1 = m1_req;
         end
      end
      e_wren  = e_g1 ? m1_we : (e_g0 & m0_we);
      e_addr  = e_g1 ? m1_addr : m0_addr;
      e_wdata = e_g1 ? m1_wdata : m0_wdata;
      e_rv0   = rst && (exp_q.size() > 0) && (id_q[0] == 1'b0);
      e_rv1   = rst && (exp_q.size() > 0) && (id_q[0] == 1'b1);
      e_rd0   = e_rv0 ? exp_q[0] : 32'd0;
      e_rd1   = e_rv1 ? exp_q[0] : 32'd0;
      e_state = (mdl_owner == 0) ? 2'd1 : (mdl_owner == 1) ? 2'd2 : 2'd0;
   endtask

   task automatic model_commit();
      logic g, lk, we;
      logic [13:0] a;
      if (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         void'(id_q.pop_front());
      end
      if (!rst) begin
         mdl_owner = -1;
         mdl_last  = 1'b1;
      end else if (e_g0 || e_g1) begin
         g  = e_g1;
         lk = g ? m1_lock : m0_lock;
         we = g ? m1_we : m0_we;
         a  = g ? m1_addr : m0_addr;
         mdl_last  = g;
         mdl_owner = lk ? (g ? 1 : 0) : -1;
         if (we) ref_mem[a] = g ? m1_wdata : m0_wdata;
         else begin
            exp_q.push_back(ref_mem[a]);
            id_q.push_back(g);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      set_m0(1, 1, 0, 14'd100, 32'hDEAD_0000);
      set_m1(1, 1, 1, 14'd101, 32'hDEAD_0001);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         model_eval();
         total++; if ({m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL reset_gnt c=%0d got=%b exp=00", c, {m0_gnt, m1_gnt}); end
         total++; if (mem_wrEn !== 1'b0) begin bad++; $display("FAIL reset_wren c=%0d got=%b exp=0", c, mem_wrEn); end
         total++; if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 0 || m1_rdata !== 0) begin
            bad++; $display("FAIL reset_rvalid c=%0d got=%b/%h/%h exp=00/0/0", c, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
         end
         model_commit();
      end
   endtask

   task automatic test_single_read();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         rst = 1'b1;
         set_m0(c == 0, 0, 0, 14'd100, 32'd0);
         set_m1(0, 0, 0, 14'd0, 32'd0);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         if (e_g0) begin
            total++; if (mem_addr !== e_addr || mem_wrEn !== 1'b0) begin bad++; $display("FAIL single_addr c=%0d got=%0d/%b exp=%0d/0", c, mem_addr, mem_wrEn, e_addr); end
         end
         total++; if (m0_rvalid !== e_rv0 || m0_rdata !== e_rd0) begin
            bad++; $display("FAIL single_rdata c=%0d got=%b/%h exp=%b/%h", c, m0_rvalid, m0_rdata, e_rv0, e_rd0);
         end
         model_commit();
      end
   endtask

   task automatic test_contention();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         set_m0(c < 8, 0, 0, 14'd101, 32'd0);
         set_m1(c < 8, 0, 0, 14'd102, 32'd0);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL cont_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         total++; if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1}) begin bad++; $display("FAIL cont_rvalid c=%0d got=%b exp=%b", c, {m0_rvalid, m1_rvalid}, {e_rv0, e_rv1}); end
         total++; if (m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
            bad++; $display("FAIL cont_rdata c=%0d got=%h/%h exp=%h/%h", c, m0_rdata, m1_rdata, e_rd0, e_rd1);
         end
         total++; if (m0_rvalid && m1_rvalid) begin bad++; $display("FAIL cont_both_rvalid c=%0d got=11 exp=not both", c); end
         model_commit();
      end
   endtask

   task automatic test_write_read();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_m0(0, 0, 0, 14'd0, 32'd0);
         set_m1(c < 2, c == 0, 0, 14'd105, 32'h12);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL wr_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         total++; if (mem_wrEn !== e_wren) begin bad++; $display("FAIL wr_wren c=%0d got=%b exp=%b", c, mem_wrEn, e_wren); end
         if (e_wren) begin
            total++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin bad++; $display("FAIL wr_bus c=%0d got=%0d/%h exp=%0d/%h", c, mem_addr, mem_wdata, e_addr, e_wdata); end
         end
         total++; if (m1_rvalid !== e_rv1 || m1_rdata !== e_rd1) begin
            bad++; $display("FAIL wr_rdata c=%0d got=%b/%h exp=%b/%h", c, m1_rvalid, m1_rdata, e_rv1, e_rd1);
         end
         model_commit();
      end
   endtask

   task automatic test_lock();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         set_m0(c == 1 || c == 2, 0, 0, 14'd103, 32'd0);
         set_m1(c < 2, c == 1, c == 0, 14'd103, 32'd0);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL lock_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         total++; if (mem_wrEn !== e_wren) begin bad++; $display("FAIL lock_wren c=%0d got=%b exp=%b", c, mem_wrEn, e_wren); end
         total++; if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1} || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
            bad++; $display("FAIL lock_rdata c=%0d got=%b/%h/%h exp=%b/%h/%h", c, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {e_rv0, e_rv1}, e_rd0, e_rd1);
         end
         model_commit();
      end
   endtask

   task automatic test_lock_idle_owner();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         set_m0(c == 0 || c == 4, c == 4, c == 0, 14'd104, 32'h77);
         set_m1(c >= 1 && c <= 5, 0, 0, 14'd106, 32'd0);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL idle_own_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         total++; if (dbg_state !== e_state) begin bad++; $display("FAIL idle_own_state c=%0d got=%0d exp=%0d", c, dbg_state, e_state); end
         total++; if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1} || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
            bad++; $display("FAIL idle_own_rdata c=%0d got=%b/%h/%h exp=%b/%h/%h", c, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {e_rv0, e_rv1}, e_rd0, e_rd1);
         end
         model_commit();
      end
   endtask

   task automatic test_reset_mid_read();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         rst = !(c == 1 || c == 2);
         set_m0(c == 0 || c == 3, 0, 0, (c == 0) ? 14'd100 : 14'd101, 32'd0);
         set_m1(c == 3 || c == 4, 0, 0, 14'd102, 32'd0);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL rst_mid_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         total++; if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1} || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
            bad++; $display("FAIL rst_mid_rdata c=%0d got=%b/%h/%h exp=%b/%h/%h", c, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {e_rv0, e_rv1}, e_rd0, e_rd1);
         end
         model_commit();
      end
   endtask

   task automatic test_random();
      logic done0 = 1'b1;
      logic done1 = 1'b1;
      rst = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         // A master keeps its request stable until granted, then rolls a new one.
         if (done0 || !m0_req)
            set_m0($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                   14'(200 + $urandom_range(0, 7)), $urandom);
         if (done1 || !m1_req)
            set_m1($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                   14'(200 + $urandom_range(0, 7)), $urandom);
         #1; model_eval();
         total++; if ({m0_gnt, m1_gnt} !== {e_g0, e_g1}) begin bad++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, {m0_gnt, m1_gnt}, {e_g0, e_g1}); end
         total++; if (mem_wrEn !== e_wren) begin bad++; $display("FAIL rand_wren c=%0d got=%b exp=%b", c, mem_wrEn, e_wren); end
         if (e_g0 || e_g1) begin
            total++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin bad++; $display("FAIL rand_bus c=%0d got=%0d/%h exp=%0d/%h", c, mem_addr, mem_wdata, e_addr, e_wdata); end
         end
         total++; if (dbg_state !== e_state) begin bad++; $display("FAIL rand_state c=%0d got=%0d exp=%0d", c, dbg_state, e_state); end
         total++; if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1} || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
            bad++; $display("FAIL rand_rdata c=%0d got=%b/%h/%h exp=%b/%h/%h", c, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {e_rv0, e_rv1}, e_rd0, e_rd1);
         end
         done0 = e_g0;
         done1 = e_g1;
         model_commit();
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b0;
      set_m0(0, 0, 0, 14'd0, 32'd0);
      set_m1(0, 0, 0, 14'd0, 32'd0);
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
      mdl_owner = -1;
      mdl_last  = 1'b1;
      test_reset();
      test_single_read();
      test_contention();
      test_write_read();
      test_lock();
      test_lock_idle_owner();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
